// File: rtl/banked_rf.sv
// -----------------------------------------------------------------------------
// banked_rf
//
// Multi-bank operand register file for the operand-collector path. Every bank
// is an independent simple dual-port memory (one read, one write per cycle)
// with per-32-bit-lane write enables and write-to-read bypass. Read results
// come back with a valid flag and the requesting collector ID. OUT_REG=1
// inserts an extra register stage, giving a read latency of 2 instead of 1.
//
// Ports (bank b uses the b-th slice of each packed bus):
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears read pipeline only)
//   rd_en        [NUM_BANKS]          read request per bank
//   rd_addr      [NUM_BANKS*ADDR_W]   read row per bank
//   rd_ocid      [NUM_BANKS*OCID_W]   collector ID per read
//   wr_en        [NUM_BANKS]          write request per bank
//   wr_addr      [NUM_BANKS*ADDR_W]   write row per bank
//   wr_mask      [NUM_BANKS*LANES]    per-lane write enable (lane = 32 bits)
//   wr_data      [NUM_BANKS*DATA_W]   write data per bank
//   rd_valid     [NUM_BANKS]          read result valid per bank
//   rd_data      [NUM_BANKS*DATA_W]   read data per bank
//   rd_ocid_out  [NUM_BANKS*OCID_W]   collector ID aligned with rd_data
// -----------------------------------------------------------------------------
module banked_rf #(
  parameter int NUM_BANKS = 4,
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 256,
  parameter int OCID_W    = 4,
  parameter int OUT_REG   = 0,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LANES    = DATA_W / 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BANKS-1:0]          rd_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_BANKS*OCID_W-1:0]   rd_ocid,
  input  logic [NUM_BANKS-1:0]          wr_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_BANKS*LANES-1:0]    wr_mask,
  input  logic [NUM_BANKS*DATA_W-1:0]   wr_data,
  output logic [NUM_BANKS-1:0]          rd_valid,
  output logic [NUM_BANKS*DATA_W-1:0]   rd_data,
  output logic [NUM_BANKS*OCID_W-1:0]   rd_ocid_out
);

  // Rows at or beyond DEPTH do not exist: writes there are dropped and reads
  // return zero. Needed whenever DEPTH is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) < DEPTH;
  endfunction

  // Lane-wise overlay of new data onto an existing row.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_row,
    input logic [DATA_W-1:0] new_row,
    input logic [LANES-1:0]  mask
  );
    logic [DATA_W-1:0] res;
    res = old_row;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) res[l*32 +: 32] = new_row[l*32 +: 32];
    end
    return res;
  endfunction

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;
    logic [LANES-1:0]  wm;
    logic [DATA_W-1:0] wd;
    logic [OCID_W-1:0] ro;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_row;

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic [OCID_W-1:0] ocid_p0;

    assign ra    = rd_addr[b*ADDR_W +: ADDR_W];
    assign wa    = wr_addr[b*ADDR_W +: ADDR_W];
    assign wm    = wr_mask[b*LANES  +: LANES];
    assign wd    = wr_data[b*DATA_W +: DATA_W];
    assign ro    = rd_ocid[b*OCID_W +: OCID_W];
    assign wr_ok = wr_en[b] && in_range(wa);
    assign rd_ok = in_range(ra);

    // Storage array: lane-enabled write port, no reset so it maps to RAM.
    always_ff @(posedge clk) begin
      if (wr_ok) begin
        for (int l = 0; l < LANES; l++) begin
          if (wm[l]) mem[wa][l*32 +: 32] <= wd[l*32 +: 32];
        end
      end
    end

    // Read row as it will look after this edge: a same-row write overlays
    // its enabled lanes so the reader sees the freshly written data.
    always_comb begin
      rd_row = '0;
      if (rd_ok) begin
        rd_row = mem[ra];
        if (wr_ok && (wa == ra)) rd_row = merge_lanes(rd_row, wd, wm);
      end
    end

    // ---- stage p0: read capture --------------------------------------------
    // Data and ocid only load on a request so they hold between reads; the
    // reset clears them because the outputs must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p0  <= 1'b0;
        data_p0 <= '0;
        ocid_p0 <= '0;
      end else begin
        vld_p0 <= rd_en[b];
        if (rd_en[b]) begin
          data_p0 <= rd_row;
          ocid_p0 <= ro;
        end
      end
    end

    if (OUT_REG != 0) begin : g_out_reg
      logic              vld_p1;
      logic [DATA_W-1:0] data_p1;
      logic [OCID_W-1:0] ocid_p1;

      // ---- stage p1: optional output register ------------------------------
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
          ocid_p1 <= '0;
        end else begin
          vld_p1  <= vld_p0;
          data_p1 <= data_p0;
          ocid_p1 <= ocid_p0;
        end
      end

      assign rd_valid[b]                    = vld_p1;
      assign rd_data[b*DATA_W +: DATA_W]    = data_p1;
      assign rd_ocid_out[b*OCID_W +: OCID_W] = ocid_p1;
    end else begin : g_no_out_reg
      assign rd_valid[b]                    = vld_p0;
      assign rd_data[b*DATA_W +: DATA_W]    = data_p0;
      assign rd_ocid_out[b*OCID_W +: OCID_W] = ocid_p0;
    end
  end

endmodule

// File: tb/tb_banked_rf.sv
// -----------------------------------------------------------------------------
// tb_banked_rf
//
// Drives two banked_rf builds with identical stimulus:
//   u_dut_a : DEPTH=8, OUT_REG=0 (latency 1)
//   u_dut_b : DEPTH=6, OUT_REG=1 (latency 2, rows 6..7 out of range)
// A behavioural model (row arrays plus expected output registers) predicts
// every output; directed scenarios add checks against fixed constants.
// -----------------------------------------------------------------------------
module tb_banked_rf;
  localparam int NB = 4;
  localparam int DW = 256;
  localparam int OW = 4;
  localparam int AW = 3;
  localparam int LN = DW / 32;
  localparam int DEPTH_B = 6;

  logic              clk;
  logic              rst_n;
  logic [NB-1:0]     rd_en;
  logic [NB*AW-1:0]  rd_addr;
  logic [NB*OW-1:0]  rd_ocid;
  logic [NB-1:0]     wr_en;
  logic [NB*AW-1:0]  wr_addr;
  logic [NB*LN-1:0]  wr_mask;
  logic [NB*DW-1:0]  wr_data;

  logic [NB-1:0]     a_valid, b_valid;
  logic [NB*DW-1:0]  a_data, b_data;
  logic [NB*OW-1:0]  a_ocid, b_ocid;

  banked_rf #(.NUM_BANKS(NB), .DEPTH(8), .DATA_W(DW), .OCID_W(OW), .OUT_REG(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ocid(rd_ocid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_valid(a_valid), .rd_data(a_data), .rd_ocid_out(a_ocid)
  );

  banked_rf #(.NUM_BANKS(NB), .DEPTH(DEPTH_B), .DATA_W(DW), .OCID_W(OW), .OUT_REG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ocid(rd_ocid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_valid(b_valid), .rd_data(b_data), .rd_ocid_out(b_ocid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ma [NB][8];
  logic [DW-1:0] mb [NB][8];
  logic          ea_v  [NB];
  logic [DW-1:0] ea_d  [NB];
  logic [OW-1:0] ea_o  [NB];
  logic          eb1_v [NB];
  logic [DW-1:0] eb1_d [NB];
  logic [OW-1:0] eb1_o [NB];
  logic          eb2_v [NB];
  logic [DW-1:0] eb2_d [NB];
  logic [OW-1:0] eb2_o [NB];

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      ea_v[b] = 1'b0;  ea_d[b] = '0;  ea_o[b] = '0;
      eb1_v[b] = 1'b0; eb1_d[b] = '0; eb1_o[b] = '0;
      eb2_v[b] = 1'b0; eb2_d[b] = '0; eb2_o[b] = '0;
    end
  endtask

  // One clock edge: writes land first, so a same-edge read sees the merged
  // row (new lanes where enabled, old elsewhere).
  task automatic model_edge();
    int wa, ra;
    for (int b = 0; b < NB; b++) begin
      eb2_v[b] = eb1_v[b]; eb2_d[b] = eb1_d[b]; eb2_o[b] = eb1_o[b];
    end
    for (int b = 0; b < NB; b++) begin
      wa = int'(wr_addr[b*AW +: AW]);
      if (wr_en[b]) begin
        for (int l = 0; l < LN; l++) begin
          if (wr_mask[b*LN + l]) begin
            ma[b][wa][l*32 +: 32] = wr_data[b*DW + l*32 +: 32];
            if (wa < DEPTH_B) mb[b][wa][l*32 +: 32] = wr_data[b*DW + l*32 +: 32];
          end
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      ra = int'(rd_addr[b*AW +: AW]);
      ea_v[b]  = rd_en[b];
      eb1_v[b] = rd_en[b];
      if (rd_en[b]) begin
        ea_d[b]  = ma[b][ra];
        ea_o[b]  = rd_ocid[b*OW +: OW];
        eb1_d[b] = (ra < DEPTH_B) ? mb[b][ra] : '0;
        eb1_o[b] = rd_ocid[b*OW +: OW];
      end
    end
    if (!rst_n) model_clear();
  endtask

  task automatic compare_all();
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("a_vld[%0d]", b),  DW'(a_valid[b]),         DW'(ea_v[b]));
      chk($sformatf("a_data[%0d]", b), a_data[b*DW +: DW],      ea_d[b]);
      chk($sformatf("a_ocid[%0d]", b), DW'(a_ocid[b*OW +: OW]), DW'(ea_o[b]));
      chk($sformatf("b_vld[%0d]", b),  DW'(b_valid[b]),         DW'(eb2_v[b]));
      chk($sformatf("b_data[%0d]", b), b_data[b*DW +: DW],      eb2_d[b]);
      chk($sformatf("b_ocid[%0d]", b), DW'(b_ocid[b*OW +: OW]), DW'(eb2_o[b]));
    end
  endtask

  // Inputs are changed only at posedge+1, so the model sees exactly what the
  // DUTs sampled.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rd_en = '0;
    wr_en = '0;
  endtask

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int l = 0; l < LN; l++) r[l*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_wr(input int b, input int addr, input logic [LN-1:0] mask, input logic [DW-1:0] data);
    wr_en[b]             = 1'b1;
    wr_addr[b*AW +: AW]  = AW'(addr);
    wr_mask[b*LN +: LN]  = mask;
    wr_data[b*DW +: DW]  = data;
  endtask

  task automatic set_rd(input int b, input int addr, input logic [OW-1:0] ocid);
    rd_en[b]             = 1'b1;
    rd_addr[b*AW +: AW]  = AW'(addr);
    rd_ocid[b*OW +: OW]  = ocid;
  endtask

  task automatic randomize_inputs();
    logic [LN-1:0] m;
    for (int b = 0; b < NB; b++) begin
      rd_en[b]            = 1'($urandom_range(0, 1));
      rd_addr[b*AW +: AW] = AW'($urandom_range(0, 7));
      rd_ocid[b*OW +: OW] = OW'($urandom);
      wr_en[b]            = 1'($urandom_range(0, 1));
      wr_addr[b*AW +: AW] = AW'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = '1;
        default: m = LN'($urandom);
      endcase
      wr_mask[b*LN +: LN] = m;
      wr_data[b*DW +: DW] = rand_row();
    end
  endtask

  logic [DW-1:0] exp_row;

  initial begin
    rst_n   = 1'b1;
    rd_addr = '0; rd_ocid = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    idle();
    model_clear();
    #1 rst_n = 1'b0;
    #2;
    compare_all();
    step();
    step();
    rst_n = 1'b1;

    // Give every row a known value (zero) before any read.
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < NB; b++) set_wr(b, r, '1, '0);
      step();
    end
    idle();
    step();

    // Full write then read, bank2 row5.
    set_wr(2, 5, 8'hFF, {LN{32'hA5A5A5A5}});
    step();
    idle();
    set_rd(2, 5, 4'h9);
    step();
    idle();
    chk("a_lat1_vld",  DW'(a_valid[2]),     DW'(1'b1));
    chk("a_lat1_data", a_data[2*DW +: DW],  {LN{32'hA5A5A5A5}});
    chk("a_lat1_ocid", DW'(a_ocid[2*OW +: OW]), DW'(4'h9));
    chk("b_lat1_vld",  DW'(b_valid[2]),     DW'(1'b0));
    step();
    chk("b_lat2_vld",  DW'(b_valid[2]),     DW'(1'b1));
    chk("b_lat2_data", b_data[2*DW +: DW],  {LN{32'hA5A5A5A5}});
    chk("b_lat2_ocid", DW'(b_ocid[2*OW +: OW]), DW'(4'h9));
    chk("a_vld_drop",  DW'(a_valid[2]),     DW'(1'b0));

    // Lane-masked write, then an all-zero mask write that must not change it.
    set_wr(0, 3, 8'hFF, {LN{32'h11111111}});
    step();
    set_wr(0, 3, 8'h81, {LN{32'hFFFFFFFF}});
    step();
    set_wr(0, 3, 8'h00, rand_row());
    step();
    idle();
    set_rd(0, 3, 4'h3);
    step();
    idle();
    exp_row = {32'hFFFFFFFF, {6{32'h11111111}}, 32'hFFFFFFFF};
    chk("lane_mask", a_data[0 +: DW], exp_row);

    // Same-edge write and read of bank0 row1 (old value zero).
    set_wr(0, 1, 8'h0F, {LN{32'hDEADBEEF}});
    set_rd(0, 1, 4'h5);
    step();
    idle();
    exp_row = {{4{32'h00000000}}, {4{32'hDEADBEEF}}};
    chk("bypass_a", a_data[0 +: DW], exp_row);
    step();
    chk("bypass_b", b_data[0 +: DW], exp_row);

    // Streaming: all banks read every cycle for 8 cycles.
    for (int c = 0; c < 8; c++) begin
      for (int b = 0; b < NB; b++) set_rd(b, (c + b) % DEPTH_B, OW'(c));
      step();
      chk($sformatf("stream_a_vld%0d", c), DW'(a_valid), DW'(4'hF));
      chk($sformatf("stream_a_ocid%0d", c), DW'(a_ocid[0 +: OW]), DW'(c));
      if (c > 0) chk($sformatf("stream_b_vld%0d", c), DW'(b_valid), DW'(4'hF));
    end
    idle();
    step();
    chk("stream_b_last", DW'(b_valid), DW'(4'hF));
    chk("stream_b_ocid", DW'(b_ocid[OW +: OW]), DW'(4'h7));

    // Out of range on the DEPTH=6 build: write and read row 7.
    for (int b = 0; b < NB; b++) set_wr(b, 7, 8'hFF, rand_row());
    step();
    idle();
    for (int b = 0; b < NB; b++) set_rd(b, 7, OW'(b + 10));
    step();
    idle();
    step();
    chk("oob_b_vld",  DW'(b_valid), DW'(4'hF));
    chk("oob_b_data", b_data[DW +: DW], '0);
    chk("oob_b_ocid", DW'(b_ocid[OW +: OW]), DW'(4'd11));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end

    // Reset asserted while reads are in flight.
    idle();
    for (int b = 0; b < NB; b++) set_rd(b, b, OW'(b + 1));
    step();
    idle();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_a_vld",  DW'(a_valid), '0);
    chk("rst_b_vld",  DW'(b_valid), '0);
    chk("rst_a_data", a_data[0 +: DW], '0);
    chk("rst_b_data", b_data[DW +: DW], '0);
    chk("rst_b_ocid", DW'(b_ocid), '0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_drop_b", DW'(b_valid), '0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
